// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: write sets the pointer then stores bytes,
// read streams bytes from reg_rdata. Both directions auto-increment the pointer.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   start_det, stop_det, scl_rise, scl_fall;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       busy_q, busy_d;

  // Synchronizers preset to the idle-bus level so reset never looks like a START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign scl_rise  = ~scl_prev_q & scl_s;
  assign scl_fall  = scl_prev_q & ~scl_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: ;
      ADDR, PTR, WR: begin
        if (scl_rise && cnt_q != 4'd8) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
        end else if (scl_fall && cnt_q == 4'd8) begin
          cnt_d = 4'd0;
          if (state_q == ADDR) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else if (state_q == PTR) begin
            state_d    = PTR_ACK;
            sda_oe_d   = 1'b1;
            reg_addr_d = shift_q;
          end else begin
            state_d     = WR_ACK;
            sda_oe_d    = 1'b1;
            reg_wdata_d = shift_q;
            reg_we_d    = 1'b1;
          end
        end
      end
      ADDR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
          if (shift_q[0]) begin
            state_d  = RD;
            reg_re_d = 1'b1;
          end else begin
            state_d = PTR;
          end
        end
      end
      PTR_ACK, WR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
          state_d  = WR;
          if (state_q == WR_ACK) reg_addr_d = reg_addr_q + 8'd1;
        end
      end
      RD: begin
        // The cycle after the read strobe carries valid reg_rdata: latch it and drive the MSB.
        if (reg_re_q) begin
          shift_d  = reg_rdata;
          sda_oe_d = ~reg_rdata[7];
          cnt_d    = 4'd0;
        end else if (scl_fall) begin
          if (cnt_q == 4'd7) begin
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            state_d  = RD_ACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
            cnt_d    = cnt_q + 4'd1;
          end
        end
      end
      RD_ACK: begin
        if (scl_rise) begin
          ack_d = ~sda_s;
          if (sda_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
          end
        end else if (scl_fall && ack_q) begin
          reg_addr_d = reg_addr_q + 8'd1;
          reg_re_d   = 1'b1;
          state_d    = RD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      reg_we_d = 1'b0;
      reg_re_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      reg_we_d = 1'b0;
      reg_re_d = 1'b0;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench acting as I2C controller with a read-only register bank; expected bus and
// strobe activity is computed from the transaction contents.
module tb_i2c_target;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       sda_line;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  logic [15:0] we_log[$];
  logic [7:0]  re_log[$];
  logic [7:0]  wdata_q[$];
  int          both_err = 0;
  int          width_err = 0;
  logic        prev_we = 1'b0;
  logic        prev_re = 1'b0;
  logic        oe_seen = 1'b0;

  assign sda_line = sda_ctrl & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'h48), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb reg_rdata = mem[reg_addr];

  always @(negedge clk) begin
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_log.push_back(reg_addr);
    if (reg_we && reg_re) both_err <= both_err + 1;
    if ((reg_we && prev_we) || (reg_re && prev_re)) width_err <= width_err + 1;
    if (sda_oe) oe_seen <= 1'b1;
    prev_we <= reg_we;
    prev_re <= reg_re;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic line_o);
    sda_ctrl = b;  wait_q();
    scl = 1'b1;    wait_q();
    line_o = sda_line;
    wait_q();
    scl = 1'b0;    wait_q();
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; wait_q();
    scl = 1'b1;      wait_q();
    sda_ctrl = 1'b0; wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0; wait_q();
    scl = 1'b1;      wait_q();
    sda_ctrl = 1'b1; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) bit_io(b[i], dummy);
    bit_io(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic bit_v, dummy;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, bit_v);
      d[i] = bit_v;
    end
    bit_io(nack, dummy);
  endtask

  // Pointer write followed by every byte in wdata_q; strobes expected at ptr+i mod 256.
  task automatic do_write(input logic [7:0] ptr);
    logic       ack;
    logic [7:0] a;
    we_log.delete();
    re_log.delete();
    i2c_start();
    send_byte(8'h90, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_busy", busy, 1);
    send_byte(ptr, ack);
    chk("wr_ptr_ack", ack, 0);
    foreach (wdata_q[i]) begin
      send_byte(wdata_q[i], ack);
      chk("wr_data_ack", ack, 0);
    end
    i2c_stop();
    wait_q();
    chk("wr_busy_after_stop", busy, 0);
    chk("wr_we_count", we_log.size(), wdata_q.size());
    foreach (wdata_q[i]) begin
      a = ptr + 8'(i);
      if (i < we_log.size()) chk("wr_we_addr_data", we_log[i], {a, wdata_q[i]});
    end
    chk("wr_no_re", re_log.size(), 0);
    $display("txn write ptr=%02h bytes=%0d", ptr, wdata_q.size());
  endtask

  // Pointer set, repeated START, then n bytes read from mem[ptr+i]; last byte NACKed.
  task automatic do_read(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] d, a;
    we_log.delete();
    re_log.delete();
    i2c_start();
    send_byte(8'h90, ack);
    chk("rd_addr_ack", ack, 0);
    send_byte(ptr, ack);
    chk("rd_ptr_ack", ack, 0);
    i2c_start();
    send_byte(8'h91, ack);
    chk("rd_addr2_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      a = ptr + 8'(i);
      recv_byte(i == n - 1, d);
      chk("rd_data", d, mem[a]);
    end
    chk("rd_busy_after_nack", busy, 1);
    chk("rd_oe_after_nack", sda_oe, 0);
    i2c_stop();
    wait_q();
    chk("rd_busy_after_stop", busy, 0);
    chk("rd_re_count", re_log.size(), n);
    for (int i = 0; i < n; i++) begin
      a = ptr + 8'(i);
      if (i < re_log.size()) chk("rd_re_addr", re_log[i], a);
    end
    chk("rd_no_we", we_log.size(), 0);
    $display("txn read ptr=%02h bytes=%0d", ptr, n);
  endtask

  task automatic do_mismatch(input logic [6:0] addr7);
    logic ack;
    we_log.delete();
    re_log.delete();
    oe_seen = 1'b0;
    i2c_start();
    send_byte({addr7, 1'b0}, ack);
    chk("mm_addr_nack", ack, 1);
    send_byte(8'($urandom), ack);
    chk("mm_data_nack", ack, 1);
    chk("mm_busy", busy, 0);
    i2c_stop();
    wait_q();
    chk("mm_oe_never", oe_seen, 0);
    chk("mm_no_we", we_log.size(), 0);
    chk("mm_no_re", re_log.size(), 0);
    $display("txn mismatch addr=%02h", addr7);
  endtask

  initial begin
    logic       ack, dummy;
    logic [7:0] tmp;
    logic [6:0] bad;
    int         kind, n;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'hC3;

    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    wdata_q = '{8'hA5};
    do_write(8'h05);

    do_mismatch(7'h49);

    begin
      logic [7:0] d;
      we_log.delete();
      re_log.delete();
      i2c_start();
      send_byte(8'h90, ack);
      send_byte(8'h10, ack);
      i2c_start();
      send_byte(8'h91, ack);
      recv_byte(1'b0, d);
      chk("rd_dir_b0", d, 8'h3C);
      recv_byte(1'b1, d);
      chk("rd_dir_b1", d, 8'hC3);
      i2c_stop();
      wait_q();
      chk("rd_dir_re_count", re_log.size(), 2);
      if (re_log.size() == 2) begin
        chk("rd_dir_re0", re_log[0], 8'h10);
        chk("rd_dir_re1", re_log[1], 8'h11);
      end
      $display("txn read directed ptr=10 bytes=2");
    end

    wdata_q = '{8'h11, 8'h22, 8'h33};
    do_write(8'hFE);

    we_log.delete();
    i2c_start();
    send_byte(8'h90, ack);
    send_byte(8'h20, ack);
    for (int i = 0; i < 3; i++) bit_io(1'($urandom), dummy);
    i2c_stop();
    wait_q();
    chk("part_no_we", we_log.size(), 0);
    chk("part_sda_oe", sda_oe, 0);
    chk("part_busy", busy, 0);
    send_byte(8'h90, ack);
    chk("part_idle_ignores", ack, 1);
    $display("txn partial stop after 3 bits");

    i2c_start();
    tmp = 8'h90;
    for (int i = 7; i >= 0; i--) bit_io(tmp[i], dummy);
    chk("rstack_oe_pre", sda_oe, 1);
    chk("rstack_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstack_sda_oe", sda_oe, 0);
    chk("rstack_busy", busy, 0);
    chk("rstack_reg_addr", reg_addr, 0);
    chk("rstack_reg_wdata", reg_wdata, 0);
    chk("rstack_we_re", {reg_we, reg_re}, 0);
    $display("txn reset during address ack");
    wdata_q = '{8'($urandom), 8'($urandom)};
    do_write(8'($urandom));

    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      if (kind == 0) begin
        wdata_q.delete();
        for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
        do_write(8'($urandom_range(250, 255)));
      end else if (kind == 1) begin
        do_read(8'($urandom), n);
      end else begin
        bad = 7'($urandom);
        if (bad == 7'h48) bad = 7'h50;
        do_mismatch(bad);
      end
    end

    chk("strobe_overlap", both_err, 0);
    chk("strobe_width", width_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
